// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, R-type
// function codes, multiplier FSM state encoding and a small ALU helper.
package ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    // ALUOp field of the EX control bundle
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // R-type function field (low six bits of the extended immediate)
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    // Iterative multiplier sequencing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Signed set-less-than, result is 1 or 0 in a full data word
    function automatic logic [DATA_W-1:0] slt_signed(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        return (sa < sb) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
    endfunction

endpackage

// File: rtl/ex_stage_mult_iter.sv
// Iterative 32x32 shift-add multiplier returning the low 32 bits of the
// product. Low bits of a two's-complement product do not depend on
// signedness, so a plain unsigned shift-add gives the signed result.
// Sequencing: IDLE -> (start) MUL x32 steps -> DONE -> IDLE.
module mult_iter
    import ex_stage_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    mul_state_t        r_state;
    mul_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic              w_load;
    logic              w_step;

    assign w_load = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_step = (r_state == ST_MUL) && !i_abort;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an abort always returns to IDLE
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) w_next = ST_MUL;
                ST_MUL:  if (r_cnt == {CNT_W{1'b1}}) w_next = ST_DONE;
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Step counter: cleared on load, advances once per shift-add step
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_load || i_abort) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shift-add datapath: add multiplicand when multiplier LSB is set
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (w_step) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_busy    = (r_state == ST_MUL);
    assign o_done    = (r_state == ST_DONE);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand selection, ALU, branch target adder, destination
// register select and the EX/MEM pipeline register. Multiplies are handed
// to mult_iter and stall the upstream pipeline until the product is ready.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        in_EX,
    input  logic [2:0]        in_M,
    input  logic [1:0]        in_WB,
    input  logic [DATA_W-1:0] in_add,
    input  logic [DATA_W-1:0] in_Dato1,
    input  logic [DATA_W-1:0] in_Dato2,
    input  logic [DATA_W-1:0] in_Extend,
    input  logic [4:0]        in_b20_16,
    input  logic [4:0]        in_b15_11,
    input  logic              in_flush,
    output logic [DATA_W-1:0] ou_branch_add,
    output logic              ou_zero,
    output logic [DATA_W-1:0] ou_alu,
    output logic [DATA_W-1:0] ou_Dato_2,
    output logic [4:0]        ou_wreg,
    output logic [2:0]        ou_M,
    output logic [1:0]        ou_WB,
    output logic              ou_stall
);

    logic              w_regdst;
    logic [2:0]        w_aluop;
    logic              w_alusrc;
    logic [5:0]        w_funct;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_is_mult;
    logic [4:0]        w_wreg;
    logic [DATA_W-1:0] w_branch;
    logic              w_busy;
    logic              w_done;
    logic              w_idle;
    logic              w_start;
    logic [DATA_W-1:0] w_product;
    logic [2:0]        r_hold_m;
    logic [1:0]        r_hold_wb;
    logic [4:0]        r_hold_wreg;

    assign w_regdst = in_EX[4];
    assign w_aluop  = in_EX[3:1];
    assign w_alusrc = in_EX[0];
    assign w_funct  = in_Extend[5:0];

    assign w_opb    = w_alusrc ? in_Extend : in_Dato2;
    assign w_wreg   = w_regdst ? in_b15_11 : in_b20_16;
    assign w_branch = in_add + (in_Extend << 2);

    // ALU decode; multiply is flagged here and computed by mult_iter
    always_comb begin
        w_alu_res = '0;
        w_is_mult = 1'b0;
        case (w_aluop)
            ALUOP_ADD: w_alu_res = in_Dato1 + w_opb;
            ALUOP_SUB: w_alu_res = in_Dato1 - w_opb;
            ALUOP_AND: w_alu_res = in_Dato1 & w_opb;
            ALUOP_OR:  w_alu_res = in_Dato1 | w_opb;
            ALUOP_SLT: w_alu_res = slt_signed(in_Dato1, w_opb);
            ALUOP_RTYPE: begin
                case (w_funct)
                    FUNCT_ADD:  w_alu_res = in_Dato1 + w_opb;
                    FUNCT_SUB:  w_alu_res = in_Dato1 - w_opb;
                    FUNCT_AND:  w_alu_res = in_Dato1 & w_opb;
                    FUNCT_OR:   w_alu_res = in_Dato1 | w_opb;
                    FUNCT_SLT:  w_alu_res = slt_signed(in_Dato1, w_opb);
                    FUNCT_MULT: w_is_mult = 1'b1;
                    default:    w_alu_res = '0;
                endcase
            end
            default: w_alu_res = '0;
        endcase
    end

    assign w_idle  = !w_busy && !w_done;
    assign w_start = w_idle && w_is_mult && !in_flush;

    // Stall covers the issue cycle and every shift-add cycle, never reset
    assign ou_stall = rst_n && !in_flush && (w_busy || (w_idle && w_is_mult));

    mult_iter u_mult (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (w_start),
        .i_abort   (in_flush),
        .i_a       (in_Dato1),
        .i_b       (w_opb),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_product (w_product)
    );

    // Capture the multiply's write-back controls at issue for the DONE write
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_hold_m    <= in_M;
            r_hold_wb   <= in_WB;
            r_hold_wreg <= w_wreg;
        end
    end

    // EX/MEM register: reset, bubble, multiply completion or normal capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ou_branch_add <= '0;
            ou_zero       <= 1'b0;
            ou_alu        <= '0;
            ou_Dato_2     <= '0;
            ou_wreg       <= '0;
            ou_M          <= '0;
            ou_WB         <= '0;
        end else if (in_flush || w_start || w_busy) begin
            // Bubble: kill memory and write-back, datapath fields held
            ou_M  <= '0;
            ou_WB <= '0;
        end else if (w_done) begin
            ou_branch_add <= w_branch;
            ou_zero       <= (w_product == '0);
            ou_alu        <= w_product;
            ou_Dato_2     <= in_Dato2;
            ou_wreg       <= r_hold_wreg;
            ou_M          <= r_hold_m;
            ou_WB         <= r_hold_wb;
        end else begin
            ou_branch_add <= w_branch;
            ou_zero       <= (w_alu_res == '0);
            ou_alu        <= w_alu_res;
            ou_Dato_2     <= in_Dato2;
            ou_wreg       <= w_wreg;
            ou_M          <= in_M;
            ou_WB         <= in_WB;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued as each
// cycle's inputs are driven and compared after the capturing clock edge.
module tb_ex_stage;

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] br;
        logic [31:0] d2;
        logic [4:0]  wreg;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic        bubble;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  in_EX;
    logic [2:0]  in_M;
    logic [1:0]  in_WB;
    logic [31:0] in_add, in_Dato1, in_Dato2, in_Extend;
    logic [4:0]  in_b20_16, in_b15_11;
    logic        in_flush;
    logic [31:0] ou_branch_add, ou_alu, ou_Dato_2;
    logic        ou_zero, ou_stall;
    logic [4:0]  ou_wreg;
    logic [2:0]  ou_M;
    logic [1:0]  ou_WB;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_EX         (in_EX),
        .in_M          (in_M),
        .in_WB         (in_WB),
        .in_add        (in_add),
        .in_Dato1      (in_Dato1),
        .in_Dato2      (in_Dato2),
        .in_Extend     (in_Extend),
        .in_b20_16     (in_b20_16),
        .in_b15_11     (in_b15_11),
        .in_flush      (in_flush),
        .ou_branch_add (ou_branch_add),
        .ou_zero       (ou_zero),
        .ou_alu        (ou_alu),
        .ou_Dato_2     (ou_Dato_2),
        .ou_wreg       (ou_wreg),
        .ou_M          (ou_M),
        .ou_WB         (ou_WB),
        .ou_stall      (ou_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        return p[31:0];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd2: begin
                case (fn)
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h18: r = ref_mul(a, b);
                    default: r = 32'd0;
                endcase
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic set_in(input logic [4:0] ex, input logic [2:0] m, input logic [1:0] wb,
                          input logic [31:0] add, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] ext, input logic [4:0] rt, input logic [4:0] rd);
        in_EX = ex; in_M = m; in_WB = wb; in_add = add;
        in_Dato1 = d1; in_Dato2 = d2; in_Extend = ext;
        in_b20_16 = rt; in_b15_11 = rd;
    endtask

    task automatic push_zero();
        exp_t e;
        e = '{alu: 32'd0, zero: 1'b0, br: 32'd0, d2: 32'd0, wreg: 5'd0, m: 3'd0, wb: 2'd0, bubble: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_bubble();
        exp_t e;
        e = '{alu: 32'd0, zero: 1'b0, br: 32'd0, d2: 32'd0, wreg: 5'd0, m: 3'd0, wb: 2'd0, bubble: 1'b1};
        exp_q.push_back(e);
    endtask

    // Expected record for the instruction currently on the inputs
    task automatic push_current(input logic [31:0] alu_val);
        exp_t e;
        e.alu    = alu_val;
        e.zero   = (alu_val == 32'd0);
        e.br     = in_add + (in_Extend << 2);
        e.d2     = in_Dato2;
        e.wreg   = in_EX[4] ? in_b15_11 : in_b20_16;
        e.m      = in_M;
        e.wb     = in_WB;
        e.bubble = 1'b0;
        exp_q.push_back(e);
    endtask

    // Wait for the capturing edge, then compare against the oldest expectation
    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("M", ou_M, e.m);
            chk("WB", ou_WB, e.wb);
            if (!e.bubble) begin
                chk("alu", ou_alu, e.alu);
                chk("zero", ou_zero, e.zero);
                chk("branch_add", ou_branch_add, e.br);
                chk("dato2", ou_Dato_2, e.d2);
                chk("wreg", ou_wreg, e.wreg);
            end
        end
    endtask

    // One single-cycle instruction
    task automatic do_alu(input logic [4:0] ex, input logic [2:0] m, input logic [1:0] wb,
                          input logic [31:0] add, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] ext, input logic [4:0] rt, input logic [4:0] rd);
        logic [31:0] b;
        set_in(ex, m, wb, add, d1, d2, ext, rt, rd);
        in_flush = 1'b0;
        #1;
        chk("stall_alu", ou_stall, 1'b0);
        b = ex[0] ? ext : d2;
        push_current(ref_alu(ex[3:1], ext[5:0], d1, b));
        tick_check();
    endtask

    task automatic issue_mult(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        set_in(5'b1_010_0, 3'b010, 2'b11, 32'h0000_0200, a, b, 32'h0000_0018, 5'd9, rd);
        in_flush = 1'b0;
    endtask

    // Hold a multiply through issue and MUL cycles (bubbles, stall high)
    task automatic mult_bubbles(input int n);
        for (int k = 1; k <= n; k++) begin
            #1;
            chk("stall_mul", ou_stall, 1'b1);
            push_bubble();
            tick_check();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        issue_mult(32'd5, 32'd6, 5'd4);

        // Reset: outputs cleared and stall suppressed despite a decoded mult
        #1;
        chk("stall_in_reset", ou_stall, 1'b0);
        push_zero();
        tick_check();
        push_zero();
        tick_check();
        rst_n = 1'b1;

        // add via R-type funct
        do_alu(5'b1_010_0, 3'b001, 2'b10, 32'h0000_0004, 32'd5, 32'd7, 32'h0000_0020, 5'd1, 5'd3);
        chk("add_alu", ou_alu, 32'd12);
        chk("add_wreg", ou_wreg, 5'd3);

        // beq compare and branch target
        do_alu(5'b0_001_0, 3'b100, 2'b00, 32'h0000_0100, 32'h1234, 32'h1234, 32'd4, 5'd2, 5'd6);
        chk("beq_zero", ou_zero, 1'b1);
        chk("beq_target", ou_branch_add, 32'h0000_0110);

        // signed slt and wrapping subtract
        do_alu(5'b0_101_0, 3'b000, 2'b01, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd7, 5'd8);
        chk("slt_signed", ou_alu, 32'd1);
        do_alu(5'b1_010_0, 3'b000, 2'b01, 32'h0, 32'd0, 32'd1, 32'h0000_0022, 5'd7, 5'd8);
        chk("sub_wrap", ou_alu, 32'hFFFF_FFFF);

        // unused ALUOp codes and unknown funct give zero
        do_alu(5'b1_110_0, 3'b011, 2'b11, 32'h40, 32'hABCD, 32'h1111, 32'h5, 5'd1, 5'd2);
        do_alu(5'b1_111_1, 3'b011, 2'b11, 32'h40, 32'hABCD, 32'h1111, 32'h5, 5'd1, 5'd2);
        do_alu(5'b1_010_0, 3'b011, 2'b11, 32'h40, 32'hABCD, 32'h1111, 32'h27, 5'd1, 5'd2);

        // randomised single-cycle mix, multiply excluded
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op;
            logic [5:0]  fn;
            logic [31:0] a, b, ext;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h2A;
                5: fn = 6'h27;
                default: fn = 6'h00;
            endcase
            a   = $urandom;
            b   = (i % 4 == 0) ? a : $urandom;
            ext = {$urandom_range(0, 1) ? 26'h3FF_FFFF : 26'h0, fn};
            do_alu({1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1))},
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom, a, b, ext, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // flush of a single-cycle instruction gives a bubble
        set_in(5'b1_000_0, 3'b111, 2'b11, 32'h10, 32'd1, 32'd2, 32'h0, 5'd3, 5'd4);
        in_flush = 1'b1;
        #1;
        chk("stall_flush", ou_stall, 1'b0);
        push_bubble();
        tick_check();

        // multiply -3 * 7: 33 stalled cycles, product at the 34th edge
        issue_mult(32'hFFFF_FFFD, 32'd7, 5'd12);
        mult_bubbles(33);
        #1;
        chk("stall_done", ou_stall, 1'b0);
        push_current(ref_mul(in_Dato1, in_Dato2));
        tick_check();
        chk("mult_product", ou_alu, 32'hFFFF_FFEB);
        chk("mult_wreg", ou_wreg, 5'd12);

        // instruction following the multiply proceeds normally
        do_alu(5'b1_010_0, 3'b001, 2'b10, 32'h8, 32'd100, 32'd58, 32'h22, 5'd1, 5'd5);

        // second multiply with large operands
        issue_mult(32'h8765_4321, 32'h1234_5679, 5'd13);
        mult_bubbles(33);
        #1;
        chk("stall_done2", ou_stall, 1'b0);
        push_current(ref_mul(in_Dato1, in_Dato2));
        tick_check();

        // flush at counter 10: issue edge plus 10 steps, then kill
        issue_mult(32'd11, 32'd13, 5'd14);
        mult_bubbles(11);
        in_flush = 1'b1;
        #1;
        chk("stall_mul_flush", ou_stall, 1'b0);
        push_bubble();
        tick_check();
        do_alu(5'b1_100_0, 3'b001, 2'b01, 32'h20, 32'hF0, 32'h0F, 32'h0, 5'd2, 5'd15);
        chk("after_flush_alu", ou_alu, 32'h0000_00FF);

        // reset during MUL, then lw-style address add
        issue_mult(32'd3, 32'd3, 5'd16);
        mult_bubbles(5);
        rst_n = 1'b0;
        #1;
        chk("stall_rst_mul", ou_stall, 1'b0);
        push_zero();
        tick_check();
        rst_n = 1'b1;
        do_alu(5'b0_000_1, 3'b010, 2'b11, 32'h0000_0300, 32'h40, 32'h99, 32'd8, 5'd17, 5'd18);
        chk("lw_alu", ou_alu, 32'h0000_0048);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_EX  input  5  EX control from ID/EX buffer: [4] RegDst, [3:1] ALUOp, [0] ALUSrc.
REQ-004 in_M  input  3  MEM control, passed through.
REQ-005 in_WB  input  2  WB control, passed through.
REQ-006 in_add  input  32  PC+4 of instruction.
REQ-007 in_Dato1, in_Dato2  input  32 each  register operands rs, rt.
REQ-008 in_Extend  input  32  sign-extended immediate; [5:0] is funct for R-type.
REQ-009 in_b20_16, in_b15_11  input  5 each  rt and rd fields.
REQ-010 in_flush  input  1  branch-taken kill of the instruction in EX.
REQ-011 ou_branch_add  output  32  registered branch target.
REQ-012 ou_zero  output  1  registered ALU-result-is-zero flag.
REQ-013 ou_alu  output  32  registered ALU result.
REQ-014 ou_Dato_2  output  32  registered store data (in_Dato2).
REQ-015 ou_wreg  output  5  registered destination register.
REQ-016 ou_M, ou_WB  output  3, 2  registered control pass-through.
REQ-017 ou_stall  output  1  combinational; upstream SHALL hold PC, IF/ID and ID/EX while high.

Function
REQ-018 Operand B SHALL be in_Extend when ALUSrc=1, else in_Dato2.
REQ-019 ALUOp: 000 add, 001 sub, 010 R-type by funct, 011 and, 100 or, 101 slt; 110/111 SHALL give result 0.
REQ-020 Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed), 011000 mult (low 32 bits of signed product); other funct SHALL give result 0.
REQ-021 Add/sub SHALL wrap modulo 2^32; no overflow trap.
REQ-022 ou_branch_add SHALL equal in_add + (in_Extend << 2), modulo 2^32.
REQ-023 ou_wreg SHALL be in_b15_11 when RegDst=1, else in_b20_16.
REQ-024 Non-mult instructions: one-cycle latency; all outputs captured on the edge following input presentation; ou_stall=0.
REQ-025 FSM states IDLE, MUL, DONE.
REQ-026 IDLE: on mult with in_flush=0, SHALL load multiplier, clear 5-bit counter, go to MUL; EX/MEM SHALL capture a bubble (ou_M=0, ou_WB=0).
REQ-027 MUL: one shift-add step per cycle; counter increments; after step with counter=31, go to DONE; EX/MEM captures bubbles.
REQ-028 DONE: EX/MEM SHALL capture the product with the held instruction's M/WB/wreg; next state IDLE.
REQ-029 ou_stall SHALL be 1 in IDLE with mult decoded and in_flush=0, and in MUL; 0 otherwise (including DONE).
REQ-030 Mult occupancy: 34 cycles from issue edge to product capture, inclusive of issue edge.
REQ-031 in_flush=1 in any state: EX/MEM SHALL capture ou_M=0, ou_WB=0; FSM SHALL go to IDLE; a mult SHALL not start; ou_stall SHALL be 0.
REQ-032 ou_zero SHALL reflect the same value captured into ou_alu.

Reset
REQ-033 rst_n=0 at a rising edge SHALL clear every registered output to 0, counter to 0, FSM to IDLE; rst_n overrides in_flush and any in-progress mult.
REQ-034 While rst_n=0, ou_stall SHALL be 0.

Structure
REQ-035 Shared package SHALL hold ALUOp codes, funct codes and FSM state encoding.
REQ-036 Iterative multiplier SHALL be sub-module mult_iter (start, busy/done, 32x32 signed, low 32 out); ALU decode and EX/MEM register stay in ex_stage.

Verification
REQ-037 add: ALUOp=010, funct=100000, Dato1=5, Dato2=7, RegDst=1, rd=3 -> next edge ou_alu=12, ou_zero=0, ou_wreg=3.
REQ-038 beq: ALUOp=001, Dato1=Dato2=0x1234, in_add=0x100, Extend=4 -> ou_zero=1, ou_branch_add=0x110.
REQ-039 slt signed: Dato1=0xFFFFFFFF, Dato2=1 -> ou_alu=1; sub 0-1 -> ou_alu=0xFFFFFFFF.
REQ-040 mult: Dato1=-3, Dato2=7 held -> ou_stall high 33 cycles, 33 bubbles, product captured at edge 34: ou_alu=0xFFFFFFEB.
REQ-041 in_flush asserted at MUL counter=10 -> bubble captured, FSM IDLE, ou_stall=0 next cycle, no product written.
REQ-042 rst_n=0 during MUL -> all outputs 0, ou_stall=0; after release, lw (ALUOp=000, ALUSrc=1, Dato1=0x40, Extend=8) -> ou_alu=0x48.
